core_mem_arbiter: RTL and testbench

CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

---
 rtl/core_mem_arbiter_pkg.sv | 30 +++
 rtl/core_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_core_mem_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_mem_arbiter_pkg
//  Purpose  : Shared core bus definitions (address/data/strobe range tops)
//             and the arbiter's state and response-owner encodings.
//  Contents : MEM_ADDR_R, MEM_DATA_R, MEM_STRB_R  - MSB index of each field
//             arb_state_t                         - ARB_IDLE/HOLD_I/HOLD_D
//             arb_owner_t                         - ARB_OWN_I/ARB_OWN_D
//  Revision : 1.0 - initial release
// ============================================================================
package core_mem_arbiter_pkg;

   // Bus field ranges shared across the core (fields are [X_R:0]).
   localparam int MEM_ADDR_R = 31;
   localparam int MEM_DATA_R = 63;
   localparam int MEM_STRB_R = 7;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_HOLD_I = 2'd1,
      ARB_HOLD_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      ARB_OWN_I = 1'b0,
      ARB_OWN_D = 1'b1
   } arb_owner_t;

endpackage
`default_nettype wire

// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : core_mem_arbiter
//  Purpose  : Two-requester arbiter sharing one memory port between the
//             instruction fetch (imem, read-only) and the LSU (dmem).
//             dmem wins contention unless imem has lost STARVE_LIMIT
//             consecutive cycles. A presented but ungranted request keeps
//             the port until granted or withdrawn. Responses (err) are
//             routed one cycle after acceptance to the accepting owner.
//  Ports    : g_clk, g_resetn                 - clock, async active-low reset
//             imem_req/addr -> gnt/err/rdata  - fetch requester
//             dmem_req/addr/wen/strb/wdata -> gnt/err/rdata - LSU requester
//             mem_req/addr/wen/strb/wdata <- mem_gnt/err/rdata - shared port
//  Revision : 1.0 - initial release
// ============================================================================
module core_mem_arbiter
   import core_mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  g_clk,
   input  logic                  g_resetn,
   // Instruction fetch
   input  logic                  imem_req,
   input  logic [MEM_ADDR_R:0]   imem_addr,
   output logic                  imem_gnt,
   output logic                  imem_err,
   output logic [MEM_DATA_R:0]   imem_rdata,
   // LSU
   input  logic                  dmem_req,
   input  logic [MEM_ADDR_R:0]   dmem_addr,
   input  logic                  dmem_wen,
   input  logic [MEM_STRB_R:0]   dmem_strb,
   input  logic [MEM_DATA_R:0]   dmem_wdata,
   output logic                  dmem_gnt,
   output logic                  dmem_err,
   output logic [MEM_DATA_R:0]   dmem_rdata,
   // Shared memory port
   output logic                  mem_req,
   output logic [MEM_ADDR_R:0]   mem_addr,
   output logic                  mem_wen,
   output logic [MEM_STRB_R:0]   mem_strb,
   output logic [MEM_DATA_R:0]   mem_wdata,
   input  logic                  mem_gnt,
   input  logic                  mem_err,
   input  logic [MEM_DATA_R:0]   mem_rdata
);

   localparam int                     STARVE_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [STARVE_W-1:0]    STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   arb_state_t            state;
   arb_state_t            state_nxt;
   logic                  sel_i;
   logic                  sel_d;
   logic [STARVE_W-1:0]   starve_cnt;
   logic                  rsp_pending;
   arb_owner_t            rsp_owner;
   logic                  accept;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Owner selection and next state
   // ------------------------------------------------------------------------
   always_comb begin
      sel_i     = 1'b0;
      sel_d     = 1'b0;
      state_nxt = ARB_IDLE;
      case (state)
         ARB_HOLD_I: begin
            sel_i = 1'b1;
            // Leave on grant, or if the requester withdraws (no grant given).
            state_nxt = (mem_gnt || !imem_req) ? ARB_IDLE : ARB_HOLD_I;
         end
         ARB_HOLD_D: begin
            sel_d = 1'b1;
            state_nxt = (mem_gnt || !dmem_req) ? ARB_IDLE : ARB_HOLD_D;
         end
         default: begin
            if (dmem_req && imem_req) begin
               if (starve_cnt == STARVE_MAX) begin
                  sel_i = 1'b1;
               end else begin
                  sel_d = 1'b1;
               end
            end else if (dmem_req) begin
               sel_d = 1'b1;
            end else if (imem_req) begin
               sel_i = 1'b1;
            end
            // In IDLE a selection implies the selected side is requesting.
            if (sel_i && !mem_gnt) begin
               state_nxt = ARB_HOLD_I;
            end else if (sel_d && !mem_gnt) begin
               state_nxt = ARB_HOLD_D;
            end
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Request path: zero-latency combinational mux of the selected payload
   // ------------------------------------------------------------------------
   always_comb begin
      mem_req   = 1'b0;
      mem_addr  = '0;
      mem_wen   = 1'b0;
      mem_strb  = '0;
      mem_wdata = '0;
      if (sel_i) begin
         // Fetches are always full-width reads.
         mem_req   = imem_req;
         mem_addr  = imem_addr;
         mem_strb  = '1;
      end else if (sel_d) begin
         mem_req   = dmem_req;
         mem_addr  = dmem_addr;
         mem_wen   = dmem_wen;
         mem_strb  = dmem_strb;
         mem_wdata = dmem_wdata;
      end
   end

   assign imem_gnt = mem_gnt && sel_i && imem_req;
   assign dmem_gnt = mem_gnt && sel_d && dmem_req;
   assign accept   = imem_gnt || dmem_gnt;

   // ------------------------------------------------------------------------
   // Response routing: remember who was accepted last cycle
   // ------------------------------------------------------------------------
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         rsp_pending <= 1'b0;
         rsp_owner   <= ARB_OWN_D;
      end else begin
         rsp_pending <= accept;
         if (accept) begin
            rsp_owner <= sel_i ? ARB_OWN_I : ARB_OWN_D;
         end
      end
   end

   assign imem_err   = mem_err && rsp_pending && (rsp_owner == ARB_OWN_I);
   assign dmem_err   = mem_err && rsp_pending && (rsp_owner == ARB_OWN_D);
   assign imem_rdata = mem_rdata;
   assign dmem_rdata = mem_rdata;

   // ------------------------------------------------------------------------
   // Fetch starvation counter (saturating)
   // ------------------------------------------------------------------------
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         starve_cnt <= '0;
      end else if (!imem_req || imem_gnt) begin
         starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
         starve_cnt <= starve_cnt + STARVE_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_mem_arbiter
//  Purpose  : Self-checking bench for core_mem_arbiter: directed scenarios
//             plus protocol-respecting random traffic against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_mem_arbiter;
   import core_mem_arbiter_pkg::*;

   localparam int STARVE_LIMIT = 4;
   localparam int AW = MEM_ADDR_R + 1;
   localparam int DW = MEM_DATA_R + 1;
   localparam int SW = MEM_STRB_R + 1;

   logic           g_clk = 1'b0;
   logic           g_resetn;
   logic           imem_req;
   logic [AW-1:0]  imem_addr;
   logic           imem_gnt, imem_err;
   logic [DW-1:0]  imem_rdata;
   logic           dmem_req;
   logic [AW-1:0]  dmem_addr;
   logic           dmem_wen;
   logic [SW-1:0]  dmem_strb;
   logic [DW-1:0]  dmem_wdata;
   logic           dmem_gnt, dmem_err;
   logic [DW-1:0]  dmem_rdata;
   logic           mem_req;
   logic [AW-1:0]  mem_addr;
   logic           mem_wen;
   logic [SW-1:0]  mem_strb;
   logic [DW-1:0]  mem_wdata;
   logic           mem_gnt, mem_err;
   logic [DW-1:0]  mem_rdata;

   core_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_err(imem_err), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
      .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen),
      .mem_strb(mem_strb), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_err(mem_err), .mem_rdata(mem_rdata)
   );

   always #5 g_clk = ~g_clk;

   int checks = 0;
   int errors = 0;

   // Reference model: who (0 none, 1 imem, 2 dmem) keeps the port because it
   // was presented and not granted; how many cycles imem has been waiting;
   // who was accepted last cycle and is owed a response.
   int m_lock, m_wait, m_rsp;
   int e_sel;
   logic           e_mem_req, e_wen, e_ig, e_dg, e_ie, e_de;
   logic [AW-1:0]  e_addr;
   logic [SW-1:0]  e_strb;
   logic [DW-1:0]  e_wdata;

   function automatic void model_reset();
      m_lock = 0; m_wait = 0; m_rsp = 0;
   endfunction

   function automatic void model_expect();
      int sel;
      if (m_lock != 0)                 sel = m_lock;
      else if (imem_req && dmem_req)   sel = (m_wait >= STARVE_LIMIT) ? 1 : 2;
      else if (dmem_req)               sel = 2;
      else if (imem_req)               sel = 1;
      else                             sel = 0;
      e_sel = sel;
      e_mem_req = 1'b0; e_addr = '0; e_wen = 1'b0; e_strb = '0; e_wdata = '0;
      if (sel == 1) begin
         e_mem_req = imem_req; e_addr = imem_addr; e_strb = '1;
      end else if (sel == 2) begin
         e_mem_req = dmem_req; e_addr = dmem_addr; e_wen = dmem_wen;
         e_strb = dmem_strb; e_wdata = dmem_wdata;
      end
      e_ig = (sel == 1) && imem_req && mem_gnt;
      e_dg = (sel == 2) && dmem_req && mem_gnt;
      e_ie = mem_err && (m_rsp == 1);
      e_de = mem_err && (m_rsp == 2);
   endfunction

   function automatic void model_advance();
      m_rsp  = e_ig ? 1 : (e_dg ? 2 : 0);
      m_lock = (e_mem_req && !mem_gnt) ? e_sel : 0;
      if (imem_req && !e_ig) m_wait = (m_wait < STARVE_LIMIT) ? m_wait + 1 : m_wait;
      else                   m_wait = 0;
   endfunction

   // Inputs are driven at posedge+1, outputs sampled at posedge+3.
   task automatic settle();
      #2;
      model_expect();
   endtask

   task automatic tick();
      model_expect();
      @(posedge g_clk);
      model_advance();
      #1;
   endtask

   task automatic idle_inputs();
      imem_req = 1'b0; imem_addr = '0;
      dmem_req = 1'b0; dmem_addr = '0; dmem_wen = 1'b0;
      dmem_strb = '0; dmem_wdata = '0;
      mem_gnt = 1'b0; mem_err = 1'b0; mem_rdata = '0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      idle_inputs();
      g_resetn = 1'b0;
      mem_err  = 1'b1;
      #3;
      checks++;
      if ({mem_req, imem_gnt, dmem_gnt, imem_err, dmem_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b want 00000",
                  {mem_req, imem_gnt, dmem_gnt, imem_err, dmem_err});
      end
      @(negedge g_clk);
      g_resetn = 1'b1;
      mem_err  = 1'b0;
      model_reset();
      @(posedge g_clk);
      #1;
      settle();
      checks++;
      if (dut.state !== ARB_IDLE || dut.starve_cnt !== '0) begin
         errors++;
         $display("FAIL reset_state: got state %0d cnt %0d want 0 0",
                  dut.state, dut.starve_cnt);
      end
      tick();
   endtask

   // Both requesting with a constant grant: dmem wins 4 times, then imem.
   task automatic test_starvation();
      imem_req = 1'b1; imem_addr = 32'h1000;
      dmem_req = 1'b1; mem_gnt = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         dmem_addr = 32'h2000 + 32'(c);
         settle();
         checks++;
         if ({imem_gnt, dmem_gnt} !== {c == 5, c != 5}) begin
            errors++;
            $display("FAIL starve_cycle%0d: got i/d gnt %b%b want %b%b",
                     c, imem_gnt, dmem_gnt, c == 5, c != 5);
         end
         tick();
      end
      idle_inputs();
      settle();
      checks++;
      if (dut.starve_cnt !== '0) begin
         errors++;
         $display("FAIL starve_clear: got %0d want 0", dut.starve_cnt);
      end
      tick();
   endtask

   // imem holds the port while ungranted even after dmem starts requesting.
   task automatic test_hold_i();
      imem_req = 1'b1; imem_addr = 32'hA0; mem_gnt = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         if (c == 2) begin
            dmem_req = 1'b1; dmem_addr = 32'hB0; dmem_wen = 1'b1;
            dmem_strb = 8'h03; dmem_wdata = 64'h55;
         end
         if (c == 4) mem_gnt = 1'b1;
         settle();
         checks++;
         if ({mem_req, mem_addr, mem_wen, imem_gnt, dmem_gnt} !==
             {1'b1, 32'hA0, 1'b0, c == 4, 1'b0}) begin
            errors++;
            $display("FAIL hold_i_cycle%0d: got req %b addr %h wen %b gnt %b%b want 1 a0 0 %b0",
                     c, mem_req, mem_addr, mem_wen, imem_gnt, dmem_gnt, c == 4);
         end
         tick();
      end
      imem_req = 1'b0;
      settle();
      checks++;
      if ({dmem_gnt, mem_addr} !== {1'b1, 32'hB0}) begin
         errors++;
         $display("FAIL hold_i_then_d: got gnt %b addr %h want 1 b0", dmem_gnt, mem_addr);
      end
      tick();
      idle_inputs();
   endtask

   // D accepted in N, I accepted in N+1; errors routed per owner.
   task automatic test_back_to_back();
      dmem_req = 1'b1; dmem_addr = 32'h300; mem_gnt = 1'b1;
      settle();
      checks++;
      if (dmem_gnt !== 1'b1) begin
         errors++;
         $display("FAIL b2b_d_gnt: got %b want 1", dmem_gnt);
      end
      tick();
      dmem_req = 1'b0; imem_req = 1'b1; imem_addr = 32'h400; mem_err = 1'b1;
      settle();
      checks++;
      if ({imem_gnt, dmem_err, imem_err} !== 3'b110) begin
         errors++;
         $display("FAIL b2b_n1: got ignt/derr/ierr %b want 110",
                  {imem_gnt, dmem_err, imem_err});
      end
      tick();
      imem_req = 1'b0;
      settle();
      checks++;
      if ({dmem_err, imem_err} !== 2'b01) begin
         errors++;
         $display("FAIL b2b_n2: got derr/ierr %b want 01", {dmem_err, imem_err});
      end
      tick();
      settle();
      checks++;
      if ({dmem_err, imem_err} !== 2'b00) begin
         errors++;
         $display("FAIL b2b_n3: got derr/ierr %b want 00", {dmem_err, imem_err});
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_store_payload();
      dmem_req = 1'b1; dmem_wen = 1'b1; dmem_addr = 32'h80;
      dmem_strb = 8'h0F; dmem_wdata = 64'h1122; mem_gnt = 1'b0;
      for (int c = 0; c < 2; c++) begin
         mem_gnt = (c == 1);
         settle();
         checks++;
         if ({mem_req, mem_wen, mem_addr, mem_strb, mem_wdata, dmem_gnt} !==
             {1'b1, 1'b1, 32'h80, 8'h0F, 64'h1122, c == 1}) begin
            errors++;
            $display("FAIL store_payload%0d: got req %b wen %b addr %h strb %h wdata %h gnt %b",
                     c, mem_req, mem_wen, mem_addr, mem_strb, mem_wdata, dmem_gnt);
         end
         tick();
      end
      // dmem bus still carries store fields but is not requesting.
      dmem_req = 1'b0; imem_req = 1'b1; imem_addr = 32'h40;
      settle();
      checks++;
      if ({mem_req, mem_wen, mem_addr, mem_strb, mem_wdata} !==
          {1'b1, 1'b0, 32'h40, 8'hFF, 64'h0}) begin
         errors++;
         $display("FAIL fetch_payload: got req %b wen %b addr %h strb %h wdata %h",
                  mem_req, mem_wen, mem_addr, mem_strb, mem_wdata);
      end
      tick();
      imem_req = 1'b0;
      settle();
      checks++;
      if ({mem_req, mem_wen, mem_addr, mem_strb, mem_wdata} !== '0) begin
         errors++;
         $display("FAIL none_payload: got req %b wen %b addr %h strb %h wdata %h",
                  mem_req, mem_wen, mem_addr, mem_strb, mem_wdata);
      end
      tick();
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      dmem_req = 1'b1; dmem_addr = 32'h500; mem_gnt = 1'b1;
      settle();
      tick();
      dmem_addr = 32'h504; mem_gnt = 1'b0; mem_err = 1'b1;
      settle();
      checks++;
      if (dmem_err !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre_err: got %b want 1", dmem_err);
      end
      #1;
      g_resetn = 1'b0; dmem_req = 1'b0;
      #1;
      checks++;
      if ({mem_req, imem_gnt, dmem_gnt, imem_err, dmem_err} !== 5'b0) begin
         errors++;
         $display("FAIL rstmid_clear: got %b want 00000",
                  {mem_req, imem_gnt, dmem_gnt, imem_err, dmem_err});
      end
      @(posedge g_clk);
      #2;
      g_resetn = 1'b1;
      model_reset();
      #1;
      checks++;
      if ({dut.state == ARB_IDLE, imem_err, dmem_err} !== 3'b100) begin
         errors++;
         $display("FAIL rstmid_release: got idle/ierr/derr %b want 100",
                  {dut.state == ARB_IDLE, imem_err, dmem_err});
      end
      tick();
      mem_err = 1'b0;
      // Reset asserted while holding for dmem.
      dmem_req = 1'b1; dmem_addr = 32'h600;
      settle();
      tick();
      settle();
      checks++;
      if (dut.state !== ARB_HOLD_D) begin
         errors++;
         $display("FAIL rsthold_pre: got state %0d want %0d", dut.state, ARB_HOLD_D);
      end
      #1;
      g_resetn = 1'b0; dmem_req = 1'b0;
      #1;
      checks++;
      if (dut.state !== ARB_IDLE || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL rsthold_clear: got state %0d req %b want 0 0", dut.state, mem_req);
      end
      @(posedge g_clk);
      #2;
      g_resetn = 1'b1;
      model_reset();
      #1;
      tick();
      idle_inputs();
   endtask

   // imem withdraws while holding: no grant to anyone that cycle.
   task automatic test_drop_hold();
      imem_req = 1'b1; imem_addr = 32'h700; mem_gnt = 1'b0;
      settle();
      tick();
      imem_req = 1'b0; dmem_req = 1'b1; dmem_addr = 32'h800; mem_gnt = 1'b1;
      settle();
      checks++;
      if ({mem_req, imem_gnt, dmem_gnt} !== 3'b000) begin
         errors++;
         $display("FAIL drop_hold_gnt: got req/igt/dgt %b want 000",
                  {mem_req, imem_gnt, dmem_gnt});
      end
      tick();
      settle();
      checks++;
      if (dut.state !== ARB_IDLE || dmem_gnt !== 1'b1) begin
         errors++;
         $display("FAIL drop_hold_idle: got state %0d dgnt %b want 0 1", dut.state, dmem_gnt);
      end
      tick();
      idle_inputs();
   endtask

   // Random contention; requesters hold payload until granted.
   task automatic test_random(input int n);
      bit i_busy = 1'b0;
      bit d_busy = 1'b0;
      for (int c = 0; c < n; c++) begin
         if (!i_busy) begin
            imem_req = ($urandom_range(0, 2) != 0);
            if (imem_req) imem_addr = $urandom;
            i_busy = imem_req;
         end
         if (!d_busy) begin
            dmem_req = ($urandom_range(0, 2) != 0);
            if (dmem_req) begin
               dmem_addr = $urandom; dmem_wen = 1'($urandom_range(0, 1));
               dmem_strb = 8'($urandom); dmem_wdata = {$urandom, $urandom};
            end
            d_busy = dmem_req;
         end
         mem_gnt   = ($urandom_range(0, 3) != 0);
         mem_err   = 1'($urandom_range(0, 1));
         mem_rdata = {$urandom, $urandom};
         settle();
         checks++;
         if ({mem_req, imem_gnt, dmem_gnt, imem_err, dmem_err} !==
             {e_mem_req, e_ig, e_dg, e_ie, e_de}) begin
            errors++;
            $display("FAIL rand_ctl%0d: got req/ig/dg/ie/de %b want %b", c,
                     {mem_req, imem_gnt, dmem_gnt, imem_err, dmem_err},
                     {e_mem_req, e_ig, e_dg, e_ie, e_de});
         end
         checks++;
         if ({mem_addr, mem_wen, mem_strb, mem_wdata} !== {e_addr, e_wen, e_strb, e_wdata}) begin
            errors++;
            $display("FAIL rand_payload%0d: got %h %b %h %h want %h %b %h %h", c,
                     mem_addr, mem_wen, mem_strb, mem_wdata, e_addr, e_wen, e_strb, e_wdata);
         end
         checks++;
         if (imem_rdata !== mem_rdata || dmem_rdata !== mem_rdata) begin
            errors++;
            $display("FAIL rand_rdata%0d: got %h %h want %h", c, imem_rdata, dmem_rdata, mem_rdata);
         end
         if (e_ig) i_busy = 1'b0;
         if (e_dg) d_busy = 1'b0;
         tick();
      end
      idle_inputs();
      settle();
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      model_reset();
      test_reset();
      test_starvation();
      test_hold_i();
      test_back_to_back();
      test_store_payload();
      test_reset_mid();
      test_drop_hold();
      test_random(400);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
